saturate: RTL and testbench

- Registered output-range clamp for pixel-processing datapaths.
- Converts a widened arithmetic result (default 10-bit) into an 8-bit colour channel, clamping to 0..255.
- Sits directly after per-channel arithmetic stages such as contrast or brightness scaling, one instance per R/G/B channel.
- Flags clipped samples per sample and keeps a saturating count of clip events for debug and status.

---
 rtl/pix_pkg.sv | 11 +
 rtl/saturate_core.sv | 28 ++
 rtl/saturate.sv | 88 ++++++++
 tb/tb_saturate.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pix_pkg.sv
// Shared pixel-datapath definitions: channel widths and clamp outcome encoding.
package pix_pkg;
  localparam int PIX_W   = 8;
  localparam int ARITH_W = 10;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_OVF  = 2'd1,
    SAT_UNF  = 2'd2
  } sat_kind_e;
endpackage

// File: rtl/saturate_core.sv
// Stateless clamp of a widened arithmetic result into the 0..2^OUT_W-1 range.
module saturate_core
  import pix_pkg::*;
#(
  parameter int IN_W      = ARITH_W,
  parameter int OUT_W     = PIX_W,
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output sat_kind_e        kind
);

  // For a non-negative signed value the sign bit is 0, so checking every bit
  // above OUT_W covers both the signed and unsigned overflow cases.
  always_comb begin
    dout = din[OUT_W-1:0];
    kind = SAT_NONE;
    if (SIGNED_IN && din[IN_W-1]) begin
      dout = '0;
      kind = SAT_UNF;
    end else if (|din[IN_W-1:OUT_W]) begin
      dout = '1;
      kind = SAT_OVF;
    end
  end

endmodule

// File: rtl/saturate.sv
// Registered output clamp with per-sample clip flags and a sticky clip counter.
module saturate
  import pix_pkg::*;
#(
  parameter int IN_W      = ARITH_W,
  parameter int OUT_W     = PIX_W,
  parameter bit SIGNED_IN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  din,
  input  logic             clr_count,
  output logic             out_valid,
  output logic [OUT_W-1:0] dout,
  output logic             ovf,
  output logic             unf,
  output logic [CNT_W-1:0] sat_count
);

  if (IN_W <= OUT_W || (SIGNED_IN && IN_W < OUT_W + 2)) begin : g_bad_width
    $error("saturate: IN_W too narrow for OUT_W/SIGNED_IN");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [OUT_W-1:0] clamp_val;
  sat_kind_e        clamp_kind;

  saturate_core #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .SIGNED_IN (SIGNED_IN)
  ) u_core (
    .din  (din),
    .dout (clamp_val),
    .kind (clamp_kind)
  );

  logic             vld_q, vld_d;
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    vld_d  = in_valid;
    dout_d = dout_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    cnt_d  = cnt_q;
    if (in_valid) begin
      dout_d = clamp_val;
      ovf_d  = (clamp_kind == SAT_OVF);
      unf_d  = (clamp_kind == SAT_UNF);
    end
    // Clear beats a coincident clip event; the count sticks at full scale.
    if (clr_count) begin
      cnt_d = '0;
    end else if (in_valid && clamp_kind != SAT_NONE && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = vld_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign sat_count = cnt_q;

endmodule

// File: tb/tb_saturate.sv
// Directed scoreboard bench: default signed instance, unsigned instance, 4-bit counter instance.
module tb_saturate;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [9:0] din = '0;
  logic       clr_count = 1'b0;

  logic        vs, ovs, uns_s;
  logic [7:0]  ds;
  logic [15:0] cs;
  logic        vu, ovu, unu;
  logic [7:0]  du;
  logic [15:0] cu;
  logic        v4, ov4, un4;
  logic [7:0]  d4;
  logic [3:0]  c4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  saturate u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .clr_count(clr_count),
    .out_valid(vs), .dout(ds), .ovf(ovs), .unf(uns_s), .sat_count(cs)
  );

  saturate #(.SIGNED_IN(1'b0)) u_uns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .clr_count(clr_count),
    .out_valid(vu), .dout(du), .ovf(ovu), .unf(unu), .sat_count(cu)
  );

  saturate #(.CNT_W(4)) u_cnt4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .clr_count(clr_count),
    .out_valid(v4), .dout(d4), .ovf(ov4), .unf(un4), .sat_count(c4)
  );

  typedef struct {
    logic        vld;
    logic [7:0]  ds;
    logic        ovs, uns;
    logic [15:0] cs;
    logic [7:0]  du;
    logic        ovu;
    logic [15:0] cu;
    logic [7:0]  d4;
    logic        ov4, un4;
    logic [3:0]  c4;
  } exp_t;

  exp_t sb[$];

  // Model state for each instance
  logic [7:0]  m_ds = '0, m_du = '0, m_d4 = '0;
  logic [15:0] m_cs = '0, m_cu = '0;
  logic [3:0]  m_c4 = '0;

  task automatic clamp(input logic [9:0] d, input bit sgn,
                       output logic [7:0] o, output logic ov, output logic un);
    int v;
    v = sgn ? int'($signed(d)) : int'(d);
    ov = 1'b0; un = 1'b0;
    if (v < 0)        begin o = 8'd0;   un = 1'b1; end
    else if (v > 255) begin o = 8'd255; ov = 1'b1; end
    else              o = 8'(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [9:0] d, input logic c, input string tag);
    exp_t e;
    logic [7:0] o;
    logic ov, un;
    in_valid = v; din = d; clr_count = c;
    e.ovs = 0; e.uns = 0; e.ovu = 0; e.ov4 = 0; e.un4 = 0;
    if (rst) begin
      m_ds = '0; m_du = '0; m_d4 = '0; m_cs = '0; m_cu = '0; m_c4 = '0;
      e.vld = 1'b0;
    end else begin
      e.vld = v;
      if (v) begin
        clamp(d, 1'b1, o, ov, un);
        m_ds = o; m_d4 = o; e.ovs = ov; e.uns = un; e.ov4 = ov; e.un4 = un;
        if (!c && (ov || un)) begin
          if (m_cs != 16'hFFFF) m_cs++;
          if (m_c4 != 4'hF) m_c4++;
        end
        clamp(d, 1'b0, o, ov, un);
        m_du = o; e.ovu = ov;
        if (!c && ov && m_cu != 16'hFFFF) m_cu++;
      end
      if (c) begin m_cs = '0; m_cu = '0; m_c4 = '0; end
    end
    e.ds = m_ds; e.cs = m_cs; e.du = m_du; e.cu = m_cu; e.d4 = m_d4; e.c4 = m_c4;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, ".vld"},   32'(vs),    32'(e.vld));
    chk({tag, ".dout"},  32'(ds),    32'(e.ds));
    chk({tag, ".ovf"},   32'(ovs),   32'(e.ovs));
    chk({tag, ".unf"},   32'(uns_s), 32'(e.uns));
    chk({tag, ".cnt"},   32'(cs),    32'(e.cs));
    chk({tag, ".u_vld"}, 32'(vu),    32'(e.vld));
    chk({tag, ".u_dout"},32'(du),    32'(e.du));
    chk({tag, ".u_ovf"}, 32'(ovu),   32'(e.ovu));
    chk({tag, ".u_unf"}, 32'(unu),   32'(0));
    chk({tag, ".u_cnt"}, 32'(cu),    32'(e.cu));
    chk({tag, ".c4_dout"},32'(d4),   32'(e.d4));
    chk({tag, ".c4_ovf"},32'(ov4),   32'(e.ov4));
    chk({tag, ".c4_unf"},32'(un4),   32'(e.un4));
    chk({tag, ".c4_cnt"},32'(c4),    32'(e.c4));
  endtask

  initial begin
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b1, 10'd300, 1'b0, "rst0");
    step(1'b1, 10'd300, 1'b0, "rst1");
    rst = 1'b0;
    step(1'b0, 10'd0, 1'b0, "post_rst");
    chk("post_rst.lit_vld", 32'(vs), 32'(0));

    step(1'b1, 10'd0,   1'b0, "in0");
    step(1'b1, 10'd1,   1'b0, "in1");
    step(1'b1, 10'd128, 1'b0, "in128");
    step(1'b1, 10'd254, 1'b0, "in254");
    step(1'b1, 10'd255, 1'b0, "in255");
    chk("in255.lit_dout", 32'(ds), 32'd255);

    step(1'b1, 10'd256, 1'b0, "ov256");
    chk("ov256.lit_ovf", 32'(ovs), 32'd1);
    step(1'b1, 10'd366, 1'b0, "ov366");
    step(1'b1, 10'h1FF, 1'b0, "ov511");
    chk("ovf3.lit_cnt", 32'(cs), 32'd3);

    step(1'b1, 10'h3FF, 1'b0, "unf_m1");
    chk("unf_m1.lit_unf", 32'(uns_s), 32'd1);
    chk("unf_m1.lit_udout", 32'(du), 32'd255);
    step(1'b1, 10'h200, 1'b0, "unf_m512");
    chk("unf2.lit_cnt", 32'(cs), 32'd5);

    for (int i = 0; i < 6; i++)
      step(i[0] ? 1'b0 : 1'b1, 10'd300, 1'b0, $sformatf("gap%0d", i));
    chk("gap.lit_hold", 32'(ds), 32'd255);

    for (int i = 0; i < 20; i++)
      step(1'b1, 10'd300, 1'b0, $sformatf("fill%0d", i));
    chk("cnt4.lit_stick", 32'(c4), 32'd15);
    step(1'b1, 10'd300, 1'b1, "clr_win");
    chk("clr_win.lit_cnt4", 32'(c4), 32'd0);
    step(1'b1, 10'd300, 1'b0, "after_clr");
    chk("after_clr.lit_cnt4", 32'(c4), 32'd1);

    step(1'b1, 10'd100, 1'b0, "pre_rst");
    rst = 1'b1;
    step(1'b1, 10'd400, 1'b0, "mid_rst");
    rst = 1'b0;
    step(1'b1, 10'd42, 1'b0, "resume");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
